nvram_upload: RTL

NVRAM_UPLOAD -- requirements
Module: nvram_upload

---
 rtl/nvram_pkg.sv | 16 +
 rtl/nvram_upload.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload/download bridge.
package nvram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StReady,
    StRdAddr,
    StRdData,
    StWr
  } nvram_state_e;

  localparam logic [7:0] DefaultIdx = 8'd4;
  localparam logic [7:0] FillByte   = 8'hFF;

endpackage

// File: rtl/nvram_upload.sv
// Bridges HPS ioctl upload/download sessions onto a CPU-shared NVRAM port.
// Optional NVRAM_DIRTY_EN adds cpu_we/dirty tracking of CPU-side NVRAM writes.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int unsigned AW  = 10,
  parameter logic [7:0]  IDX = DefaultIdx
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_rd,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
`ifdef NVRAM_DIRTY_EN
  input  logic          cpu_we,
  output logic          dirty,
`endif
  output logic          ram_req,
  input  logic          ram_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata
);

  nvram_state_e state_q;

  logic          pend_q, pend_wr_q;
  logic [24:0]   pend_addr_q;
  logic [7:0]    pend_data_q;
  logic [24:0]   op_addr_q;
  logic [7:0]    op_data_q;
  logic          op_oor_q;
  logic          we_q, wait_q, req_q;
  logic [7:0]    din_q, wdata_q;
  logic [AW-1:0] addr_q;

  logic          session, rd_stb, wr_stb, stb, busy;
  logic          svc_valid, svc_wr, svc_in_range;
  logic [24:0]   svc_addr;
  logic [7:0]    svc_data;

  function automatic logic in_range(input logic [24:0] a);
    return (a >> AW) == 25'd0;
  endfunction

  assign session = (ioctl_upload | ioctl_download) && (ioctl_index == IDX);
  assign rd_stb  = session & ioctl_upload & ioctl_rd;
  assign wr_stb  = session & ioctl_download & ioctl_wr;
  assign stb     = rd_stb | wr_stb;
  assign busy    = (state_q == StRdAddr) || (state_q == StRdData) || (state_q == StWr);

  // A parked strobe always takes precedence over a live one.
  always_comb begin
    svc_valid = pend_q | stb;
    svc_wr    = pend_q ? pend_wr_q   : wr_stb;
    svc_addr  = pend_q ? pend_addr_q : ioctl_addr;
    svc_data  = pend_q ? pend_data_q : ioctl_dout;
  end

  assign svc_in_range = in_range(svc_addr);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      op_addr_q   <= '0;
      op_data_q   <= '0;
      op_oor_q    <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= 1'b0;
      req_q       <= 1'b0;
      din_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Park any strobe that cannot be serviced this cycle.
      if (stb && !pend_q && (state_q != StReady || !ram_gnt)) begin
        pend_q      <= 1'b1;
        pend_wr_q   <= wr_stb;
        pend_addr_q <= ioctl_addr;
        pend_data_q <= ioctl_dout;
      end
      if (state_q != StIdle && !session) begin
        state_q <= StIdle;
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        wait_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else if (state_q != StIdle && state_q != StReq && !ram_gnt) begin
        state_q <= StReq;
        wait_q  <= 1'b1;
        we_q    <= 1'b0;
        // Re-queue the interrupted access so the HPS is not left stalled.
        if (busy && !pend_q) begin
          pend_q      <= 1'b1;
          pend_wr_q   <= (state_q == StWr);
          pend_addr_q <= op_addr_q;
          pend_data_q <= op_data_q;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (session) begin
              state_q <= StReq;
              req_q   <= 1'b1;
              wait_q  <= 1'b1;
            end
          end
          StReq: begin
            if (ram_gnt) begin
              state_q <= StReady;
              wait_q  <= pend_q | stb;
            end
          end
          StReady: begin
            if (svc_valid) begin
              pend_q <= pend_q & stb;
              if (pend_q && stb) begin
                pend_wr_q   <= wr_stb;
                pend_addr_q <= ioctl_addr;
                pend_data_q <= ioctl_dout;
              end
              op_addr_q <= svc_addr;
              op_data_q <= svc_data;
              op_oor_q  <= !svc_in_range;
              if (svc_wr) begin
                wait_q <= pend_q & stb;
                if (svc_in_range) begin
                  state_q <= StWr;
                  addr_q  <= svc_addr[AW-1:0];
                  wdata_q <= svc_data;
                  we_q    <= 1'b1;
                end
              end else begin
                state_q <= StRdAddr;
                wait_q  <= 1'b1;
                if (svc_in_range) addr_q <= svc_addr[AW-1:0];
              end
            end
          end
          StRdAddr: state_q <= StRdData;
          StRdData: begin
            din_q   <= op_oor_q ? FillByte : ram_rdata;
            wait_q  <= pend_q | stb;
            state_q <= StReady;
          end
          StWr: begin
            we_q    <= 1'b0;
            state_q <= StReady;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_req    = req_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  // Gate with the grant so a late grant drop can never leak a write.
  assign ram_we     = we_q & ram_gnt;

`ifdef NVRAM_DIRTY_EN
  logic dirty_q, up_ready_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty_q    <= 1'b0;
      up_ready_q <= 1'b0;
    end else begin
      if (state_q == StReady && ioctl_upload) up_ready_q <= 1'b1;
      if (state_q != StIdle && !session) begin
        up_ready_q <= 1'b0;
        if (up_ready_q) dirty_q <= 1'b0;
      end
      if (cpu_we && !ram_gnt) dirty_q <= 1'b1;
    end
  end

  assign dirty = dirty_q;
`endif

endmodule
